// File: rtl/vertical_forward_stage.sv
// Vertical router stage: FIFO-buffered spike packets are routed by their signed dy field,
// either onward to the next vertical hop (dy adjusted by ADD) or to the local core (dy stripped).
module vertical_forward_stage #(
    parameter int DATA_WIDTH   = 23,
    parameter int DY_MSB       = 20,
    parameter int DY_LSB       = 12,
    parameter int ADD          = 1,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [DATA_WIDTH-1:0]                         din,
    input  logic                                          din_wen,
    output logic                                          din_full,
    output logic [DATA_WIDTH-1:0]                         dout_a,
    output logic                                          dout_a_wen,
    input  logic                                          dout_a_full,
    output logic [DATA_WIDTH-(DY_MSB-DY_LSB+1)-1:0]       dout_b,
    output logic                                          dout_b_wen,
    input  logic                                          dout_b_full
);

    localparam int DYW = DY_MSB - DY_LSB + 1;
    localparam int BW  = DATA_WIDTH - DYW;
    localparam int AW  = $clog2(BUFFER_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [AW-1:0]         rptr_reg;
    logic [AW-1:0]         wptr_reg;
    logic [AW:0]           count_reg;

    logic [DATA_WIDTH-1:0] dout_a_reg;
    logic [BW-1:0]         dout_b_reg;
    logic                  dout_a_wen_reg;
    logic                  dout_b_wen_reg;

    logic [DATA_WIDTH-1:0] head;
    logic [DYW-1:0]        dy;
    logic [DYW-1:0]        dy_next;
    logic [DATA_WIDTH-1:0] fwd_word;
    logic [BW-1:0]         local_word;
    logic                  to_local;
    logic                  push;
    logic                  pop;

    assign head     = mem[rptr_reg];
    assign dy       = head[DY_MSB:DY_LSB];
    // Wraps modulo 2^DYW; a negative ADD truncates to its two's-complement form.
    assign dy_next  = dy + DYW'(ADD);
    assign to_local = (dy == '0);

    assign din_full = (count_reg == (AW+1)'(BUFFER_DEPTH));
    assign push     = din_wen && !din_full;
    assign pop      = (count_reg != '0) && (to_local ? !dout_b_full : !dout_a_full);

    // Splice the adjusted/stripped dy field, tolerating an absent upper or lower slice.
    generate
        if (DY_MSB < DATA_WIDTH - 1 && DY_LSB > 0) begin : g_both
            assign fwd_word   = {head[DATA_WIDTH-1:DY_MSB+1], dy_next, head[DY_LSB-1:0]};
            assign local_word = {head[DATA_WIDTH-1:DY_MSB+1], head[DY_LSB-1:0]};
        end else if (DY_LSB > 0) begin : g_no_upper
            assign fwd_word   = {dy_next, head[DY_LSB-1:0]};
            assign local_word = head[DY_LSB-1:0];
        end else begin : g_no_lower
            assign fwd_word   = {head[DATA_WIDTH-1:DY_MSB+1], dy_next};
            assign local_word = head[DATA_WIDTH-1:DY_MSB+1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                wptr_reg <= wptr_reg + AW'(1);
            end
            if (pop) begin
                rptr_reg <= rptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_a_reg     <= '0;
            dout_b_reg     <= '0;
            dout_a_wen_reg <= 1'b0;
            dout_b_wen_reg <= 1'b0;
        end else begin
            dout_a_wen_reg <= pop && !to_local;
            dout_b_wen_reg <= pop && to_local;
            if (pop && !to_local) begin
                dout_a_reg <= fwd_word;
            end
            if (pop && to_local) begin
                dout_b_reg <= local_word;
            end
        end
    end

    assign dout_a     = dout_a_reg;
    assign dout_b     = dout_b_reg;
    assign dout_a_wen = dout_a_wen_reg;
    assign dout_b_wen = dout_b_wen_reg;

endmodule

// File: tb/tb_vertical_forward_stage.sv
// Directed bench for vertical_forward_stage: a south-going (ADD=+1) and a north-going (ADD=-1) instance.
module tb_vertical_forward_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [22:0] din;
    logic        din_wen;
    logic        din_full;
    logic [22:0] dout_a;
    logic        dout_a_wen;
    logic        dout_a_full;
    logic [13:0] dout_b;
    logic        dout_b_wen;
    logic        dout_b_full;

    logic [22:0] din_n;
    logic        din_wen_n;
    logic        din_full_n;
    logic [22:0] dout_a_n;
    logic        dout_a_wen_n;
    logic [13:0] dout_b_n;
    logic        dout_b_wen_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vertical_forward_stage #(.ADD(1)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_wen(din_wen), .din_full(din_full),
        .dout_a(dout_a), .dout_a_wen(dout_a_wen), .dout_a_full(dout_a_full),
        .dout_b(dout_b), .dout_b_wen(dout_b_wen), .dout_b_full(dout_b_full)
    );

    vertical_forward_stage #(.ADD(-1)) u_dut_n (
        .clk(clk), .rst(rst), .din(din_n), .din_wen(din_wen_n), .din_full(din_full_n),
        .dout_a(dout_a_n), .dout_a_wen(dout_a_wen_n), .dout_a_full(1'b0),
        .dout_b(dout_b_n), .dout_b_wen(dout_b_wen_n), .dout_b_full(1'b0)
    );

    function automatic logic [22:0] mk(input logic [1:0] u, input logic [8:0] dy, input logic [11:0] lo);
        return {u, dy, lo};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (dout_a !== 23'h0) begin bad++; $display("FAIL reset_dout_a got=%h want=%h", dout_a, 23'h0); end
        total++; if (dout_b !== 14'h0) begin bad++; $display("FAIL reset_dout_b got=%h want=%h", dout_b, 14'h0); end
        total++; if ({dout_a_wen, dout_b_wen, din_full} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {dout_a_wen, dout_b_wen, din_full}); end
        total++; if ({dout_a_wen_n, dout_b_wen_n, din_full_n} !== 3'b000) begin bad++; $display("FAIL reset_flags_n got=%b want=000", {dout_a_wen_n, dout_b_wen_n, din_full_n}); end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_forward();
        logic [22:0] exp_a;
        exp_a = mk(2'b01, 9'h1FF, 12'h123);
        @(negedge clk); din = mk(2'b01, 9'h1FE, 12'h123); din_wen = 1'b1;
        @(negedge clk); din_wen = 1'b0;
        total++; if (dout_a_wen !== 1'b0) begin bad++; $display("FAIL fwd_latency1 got=%b want=0", dout_a_wen); end
        @(negedge clk);
        total++; if (dout_a_wen !== 1'b1) begin bad++; $display("FAIL fwd_wen got=%b want=1", dout_a_wen); end
        total++; if (dout_a !== exp_a) begin bad++; $display("FAIL fwd_data got=%h want=%h", dout_a, exp_a); end
        total++; if (dout_b_wen !== 1'b0) begin bad++; $display("FAIL fwd_b_quiet got=%b want=0", dout_b_wen); end
        @(negedge clk);
        total++; if (dout_a_wen !== 1'b0) begin bad++; $display("FAIL fwd_wen_pulse got=%b want=0", dout_a_wen); end
        total++; if (dout_a !== exp_a) begin bad++; $display("FAIL fwd_hold got=%h want=%h", dout_a, exp_a); end
        $display("test_forward done: dout_a=%h", dout_a);
    endtask

    task automatic test_local();
        @(negedge clk); din = mk(2'b10, 9'h000, 12'hABC); din_wen = 1'b1;
        @(negedge clk); din_wen = 1'b0;
        @(negedge clk);
        total++; if (dout_b_wen !== 1'b1) begin bad++; $display("FAIL local_wen got=%b want=1", dout_b_wen); end
        total++; if (dout_b !== {2'b10, 12'hABC}) begin bad++; $display("FAIL local_data got=%h want=%h", dout_b, {2'b10, 12'hABC}); end
        total++; if (dout_a_wen !== 1'b0) begin bad++; $display("FAIL local_a_quiet got=%b want=0", dout_a_wen); end
        @(negedge clk);
        total++; if (dout_b_wen !== 1'b0) begin bad++; $display("FAIL local_wen_pulse got=%b want=0", dout_b_wen); end
        $display("test_local done: dout_b=%h", dout_b);
    endtask

    task automatic test_full();
        logic [22:0] exp_a;
        dout_a_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 3) begin
                total++; if (din_full !== 1'b0) begin bad++; $display("FAIL full_early got=%b want=0", din_full); end
            end
            if (k == 4) begin
                total++; if (din_full !== 1'b1) begin bad++; $display("FAIL full_after4 got=%b want=1", din_full); end
            end
            din = mk(2'(k), 9'h003, 12'(12'h100 + k)); din_wen = 1'b1;
        end
        @(negedge clk); din_wen = 1'b0;
        total++; if (din_full !== 1'b1) begin bad++; $display("FAIL full_hold got=%b want=1", din_full); end
        total++; if (dout_a_wen !== 1'b0) begin bad++; $display("FAIL full_blocked got=%b want=0", dout_a_wen); end
        dout_a_full = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_a = mk(2'(k), 9'h004, 12'(12'h100 + k));
            if (k < 4) begin
                total++; if (dout_a_wen !== 1'b1) begin bad++; $display("FAIL drain_wen%0d got=%b want=1", k, dout_a_wen); end
                total++; if (dout_a !== exp_a) begin bad++; $display("FAIL drain_data%0d got=%h want=%h", k, dout_a, exp_a); end
            end else begin
                total++; if (dout_a_wen !== 1'b0) begin bad++; $display("FAIL drain_extra%0d got=%b want=0", k, dout_a_wen); end
            end
        end
        $display("test_full done");
    endtask

    task automatic test_hol();
        dout_a_full = 1'b1;
        @(negedge clk); din = mk(2'b00, 9'h001, 12'h011); din_wen = 1'b1;
        @(negedge clk); din = mk(2'b11, 9'h000, 12'h022);
        @(negedge clk); din_wen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if ({dout_a_wen, dout_b_wen} !== 2'b00) begin bad++; $display("FAIL hol_blocked%0d got=%b want=00", k, {dout_a_wen, dout_b_wen}); end
        end
        dout_a_full = 1'b0;
        @(negedge clk);
        total++; if ({dout_a_wen, dout_b_wen} !== 2'b10) begin bad++; $display("FAIL hol_first got=%b want=10", {dout_a_wen, dout_b_wen}); end
        total++; if (dout_a !== mk(2'b00, 9'h002, 12'h011)) begin bad++; $display("FAIL hol_a_data got=%h want=%h", dout_a, mk(2'b00, 9'h002, 12'h011)); end
        @(negedge clk);
        total++; if ({dout_a_wen, dout_b_wen} !== 2'b01) begin bad++; $display("FAIL hol_second got=%b want=01", {dout_a_wen, dout_b_wen}); end
        total++; if (dout_b !== {2'b11, 12'h022}) begin bad++; $display("FAIL hol_b_data got=%h want=%h", dout_b, {2'b11, 12'h022}); end
        @(negedge clk);
        total++; if ({dout_a_wen, dout_b_wen} !== 2'b00) begin bad++; $display("FAIL hol_idle got=%b want=00", {dout_a_wen, dout_b_wen}); end
        $display("test_hol done");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        din = mk(2'b01, 9'h0FF, 12'h055); din_wen = 1'b1;
        din_n = mk(2'b01, 9'h100, 12'h055); din_wen_n = 1'b1;
        @(negedge clk); din_wen = 1'b0; din_wen_n = 1'b0;
        @(negedge clk);
        total++; if (dout_a_wen !== 1'b1 || dout_a !== mk(2'b01, 9'h100, 12'h055)) begin bad++; $display("FAIL wrap_pos got=%b/%h want=1/%h", dout_a_wen, dout_a, mk(2'b01, 9'h100, 12'h055)); end
        total++; if (dout_a_wen_n !== 1'b1 || dout_a_n !== mk(2'b01, 9'h0FF, 12'h055)) begin bad++; $display("FAIL wrap_neg got=%b/%h want=1/%h", dout_a_wen_n, dout_a_n, mk(2'b01, 9'h0FF, 12'h055)); end
        $display("test_wrap done: pos=%h neg=%h", dout_a, dout_a_n);
    endtask

    task automatic test_reset_mid();
        dout_a_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); din = mk(2'b11, 9'h005, 12'(k)); din_wen = 1'b1;
        end
        @(negedge clk); din_wen = 1'b0;
        total++; if (din_full !== 1'b1) begin bad++; $display("FAIL mid_fill got=%b want=1", din_full); end
        dout_a_full = 1'b0;
        @(negedge clk);
        total++; if (dout_a_wen !== 1'b1 || din_full !== 1'b0) begin bad++; $display("FAIL mid_pending got=%b%b want=10", dout_a_wen, din_full); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({dout_a_wen, dout_b_wen, din_full} !== 3'b000) begin bad++; $display("FAIL mid_flags got=%b want=000", {dout_a_wen, dout_b_wen, din_full}); end
        total++; if (dout_a !== 23'h0 || dout_b !== 14'h0) begin bad++; $display("FAIL mid_data got=%h/%h want=0/0", dout_a, dout_b); end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if ({dout_a_wen, dout_b_wen} !== 2'b00) begin bad++; $display("FAIL mid_quiet%0d got=%b want=00", k, {dout_a_wen, dout_b_wen}); end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        rst = 1'b1; din = '0; din_wen = 1'b0; dout_a_full = 1'b0; dout_b_full = 1'b0;
        din_n = '0; din_wen_n = 1'b0;
        test_reset();
        test_forward();
        test_local();
        test_full();
        test_hol();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
